// File: rtl/handshake_rx_responder.sv
// Responder end of the four-phase req/ack CDC handshake.
// A foreign-domain level request is synchronized into clk_source, the held
// sender word is captured and offered to a local consumer over valid/ready,
// and a registered acknowledge is returned once the consumer has taken it.
// A request that drops before the consumer accepts is flagged as a sticky
// protocol error, but the captured word is still delivered.

module handshake_rx_responder #(
  parameter int SYNC_STAGE = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_source,
  input  logic                  rst_dest,
  input  logic                  req_async,
  input  logic [DATA_WIDTH-1:0] data_async,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ack_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_e;

  logic [SYNC_STAGE-1:0] sync_q;
  logic                  req_sync;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  // Multi-flop synchronizer for the foreign request; only its last stage is used.
  always_ff @(posedge clk_source or negedge rst_dest) begin
    if (!rst_dest) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGE-2:0], req_async};
    end
  end

  assign req_sync = sync_q[SYNC_STAGE-1];

  // State and datapath registers; reset clears ack and valid without a clock.
  always_ff @(posedge clk_source or negedge rst_dest) begin
    if (!rst_dest) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: capture on request, release on accept, close on req drop.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_sync) begin
          data_d  = data_async;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        // Sender withdrew the request before the word was consumed.
        if (!req_sync) begin
          err_d = 1'b1;
        end
        if (valid_q && data_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign ack_out    = ack_q;
  assign busy       = (state_q != IDLE);
  assign xfer_cnt   = cnt_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_handshake_rx_responder.sv
// Bench for handshake_rx_responder: a cycle table for the basic transfer,
// hand-written sequences for backpressure, protocol error and reset, and a
// scoreboard of sender words checked against consumer acceptances.
// A second instance with a 4-bit counter shares the stimulus for wrap checks.

module tb_handshake_rx_responder;

  logic       clk_source;
  logic       rst_dest;
  logic       req_async;
  logic [7:0] data_async;
  logic       data_ready;

  logic [7:0]  data_out;
  logic        data_valid;
  logic        ack_out;
  logic        busy;
  logic [15:0] xfer_cnt;
  logic        proto_err;

  logic [7:0] w_data_out;
  logic       w_data_valid;
  logic       w_ack_out;
  logic       w_busy;
  logic [3:0] w_xfer_cnt;
  logic       w_proto_err;

  int checks;
  int failures;
  logic [7:0] exp_q[$];
  bit rnd_ready;

  handshake_rx_responder #(.SYNC_STAGE(2), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_source(clk_source), .rst_dest(rst_dest), .req_async(req_async),
    .data_async(data_async), .data_ready(data_ready), .data_out(data_out),
    .data_valid(data_valid), .ack_out(ack_out), .busy(busy),
    .xfer_cnt(xfer_cnt), .proto_err(proto_err)
  );

  handshake_rx_responder #(.SYNC_STAGE(2), .DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clk_source(clk_source), .rst_dest(rst_dest), .req_async(req_async),
    .data_async(data_async), .data_ready(data_ready), .data_out(w_data_out),
    .data_valid(w_data_valid), .ack_out(w_ack_out), .busy(w_busy),
    .xfer_cnt(w_xfer_cnt), .proto_err(w_proto_err)
  );

  initial clk_source = 1'b0;
  always #5 clk_source = ~clk_source;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       ea;
    logic       eb;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: scoreboard sample at the negedge, return just after the posedge.
  task automatic tick();
    logic [7:0] e;
    if (rnd_ready) data_ready = 1'($urandom_range(0, 1));
    @(negedge clk_source);
    if (rst_dest && data_valid && data_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got %0h expected none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL sb_word: got %0h expected %0h", data_out, e);
        end
      end
    end
    @(posedge clk_source);
    #1;
  endtask

  // sel 0 waits on ack_out, sel 1 on data_valid; timeout counts as a failure.
  task automatic wait_for(input int sel, input logic lvl, input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if ((sel == 0 ? ack_out : data_valid) === lvl) done = 1;
      else tick();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s: got timeout expected level %0b", nm, lvl);
    end
  endtask

  task automatic send(input logic [7:0] d);
    exp_q.push_back(d);
    data_async = d;
    req_async  = 1'b1;
    wait_for(0, 1'b1, "send_ack_rise");
    req_async  = 1'b0;
    data_async = 8'($urandom);
    wait_for(0, 1'b0, "send_ack_fall");
  endtask

  task automatic do_reset();
    rst_dest = 1'b0;
    tick();
    tick();
    rst_dest = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rnd_ready = 0;
    rst_dest = 1'b0;
    req_async = 1'b0;
    data_async = 8'h00;
    data_ready = 1'b0;

    #2;
    chk("rst_valid", data_valid, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_err", proto_err, 0);
    do_reset();

    // Row i inputs precede edge i; expectations hold just after edge i.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 9; i++) begin
      req_async  = tbl[i].req;
      data_async = tbl[i].data;
      data_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), data_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].ed);
      chk($sformatf("tbl%0d_ack", i), ack_out, tbl[i].ea);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
    end
    chk("single_cnt", xfer_cnt, 1);

    // Backpressure holds the word and withholds ack.
    data_ready = 1'b0;
    exp_q.push_back(8'h3C);
    data_async = 8'h3C;
    req_async  = 1'b1;
    wait_for(1, 1'b1, "bp_valid");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold", {data_valid, ack_out, data_out}, {1'b1, 1'b0, 8'h3C});
    end
    data_ready = 1'b1;
    tick();
    chk("bp_ack", ack_out, 1);
    chk("bp_valid_drop", data_valid, 0);
    req_async = 1'b0;
    wait_for(0, 1'b0, "bp_ack_fall");
    chk("bp_cnt", xfer_cnt, 2);

    // Back-to-back transfers with random consumer readiness.
    do_reset();
    rnd_ready = 1;
    for (int i = 0; i < 100; i++) send(8'($urandom));
    rnd_ready = 0;
    data_ready = 1'b0;
    tick();
    chk("b2b_cnt", xfer_cnt, 100);
    chk("b2b_wcnt", w_xfer_cnt, 4);
    chk("b2b_err", proto_err, 0);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // Request withdrawn while the word is still pending.
    exp_q.push_back(8'h55);
    data_async = 8'h55;
    req_async  = 1'b1;
    wait_for(1, 1'b1, "pv_valid");
    req_async = 1'b0;
    tick();
    tick();
    tick();
    chk("pv_err", proto_err, 1);
    chk("pv_hold", {data_valid, ack_out, data_out}, {1'b1, 1'b0, 8'h55});
    data_ready = 1'b1;
    tick();
    chk("pv_ack_hi", ack_out, 1);
    tick();
    chk("pv_ack_lo", ack_out, 0);
    chk("pv_busy", busy, 0);
    chk("pv_err_sticky", proto_err, 1);

    // Asynchronous reset while in ACK.
    do_reset();
    chk("rr_err_clr", proto_err, 0);
    data_ready = 1'b1;
    exp_q.push_back(8'h77);
    data_async = 8'h77;
    req_async  = 1'b1;
    wait_for(0, 1'b1, "rr_ack");
    chk("rr_in_ack", busy, 1);
    rst_dest = 1'b0;
    #1;
    chk("rr_ack_async", ack_out, 0);
    chk("rr_valid_async", data_valid, 0);
    chk("rr_busy_async", busy, 0);
    chk("rr_cnt_async", xfer_cnt, 0);
    req_async = 1'b0;
    tick();
    tick();
    rst_dest = 1'b1;
    tick();
    send(8'h99);
    chk("rr_cnt", xfer_cnt, 1);
    chk("rr_dout", data_out, 8'h99);

    // Wrap of the 4-bit counter.
    do_reset();
    data_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(i * 7 + 3));
    chk("wrap_wcnt", w_xfer_cnt, 1);
    chk("wrap_cnt", xfer_cnt, 17);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
